// File: rtl/prog_memory_pkg.sv
// Shared types and constants for the writable program memory.
package prog_memory_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   // Replicated across the word width to form the NOP encoding.
   localparam logic NOP_BIT = 1'b0;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/prog_memory_array.sv
// Single-port synchronous RAM with registered, enable-gated read; no reset on storage.
module prog_memory_array
   import prog_memory_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   output logic [DATA_W-1:0] rdata_p1
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      if (re) begin
         rdata_p1 <= mem[addr];
      end
   end

endmodule

// File: rtl/prog_memory.sv
// Writable program memory: clears to FILL after reset, loads word-serially, serves 1-cycle fetches.
module prog_memory
   import prog_memory_pkg::*;
#(
   parameter int                ADDR_W = 6,
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] FILL   = {DATA_W{NOP_BIT}}
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic              RD_EN,
   output logic [DATA_W-1:0] DATA,
   output logic              READY,
   input  logic              LD_START,
   input  logic              LD_VALID,
   input  logic [DATA_W-1:0] LD_DATA,
   input  logic              LD_LAST,
   output logic              LD_READY,
   output logic              LD_DONE,
   output logic              LD_ERR
);

   state_t            state;
   logic [ADDR_W:0]   ptr;
   logic              ld_done_q;
   logic              ld_err_q;
   logic              vld_p1;
   logic              full;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;
   logic [DATA_W-1:0] rdata_p1;

   // The extra pointer bit marks "all DEPTH words written" during a load.
   assign full = ptr[ADDR_W];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_CLEAR;
         ptr       <= '0;
         ld_done_q <= 1'b0;
         ld_err_q  <= 1'b0;
         vld_p1    <= 1'b0;
      end else begin
         ld_done_q <= 1'b0;
         case (state)
            ST_CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (RD_EN) begin
                  vld_p1 <= 1'b1;
               end
               if (LD_START) begin
                  state    <= ST_LOAD;
                  ptr      <= '0;
                  ld_err_q <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (LD_VALID) begin
                  if (full) begin
                     ld_err_q <= 1'b1;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
                  if (LD_LAST) begin
                     state     <= ST_IDLE;
                     ld_done_q <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_CLEAR;
               ptr   <= '0;
            end
         endcase
      end
   end

   // Modes never overlap, so one RAM port is shared between clear, load and fetch.
   always_comb begin
      mem_addr  = ADDR;
      mem_we    = 1'b0;
      mem_wdata = LD_DATA;
      mem_re    = 1'b0;
      case (state)
         ST_CLEAR: begin
            mem_addr  = ptr[ADDR_W-1:0];
            mem_we    = 1'b1;
            mem_wdata = FILL;
         end
         ST_IDLE: begin
            mem_re = RD_EN;
         end
         ST_LOAD: begin
            mem_addr = ptr[ADDR_W-1:0];
            mem_we   = LD_VALID && !full;
         end
         default: begin
            mem_addr = ADDR;
         end
      endcase
   end

   prog_memory_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk      (CLK),
      .addr     (mem_addr),
      .we       (mem_we),
      .wdata    (mem_wdata),
      .re       (mem_re),
      .rdata_p1 (rdata_p1)
   );

   // Storage has no reset, so DATA reads as zero until the first fetch lands.
   assign DATA     = vld_p1 ? rdata_p1 : '0;
   assign READY    = (state == ST_IDLE);
   assign LD_READY = (state == ST_LOAD);
   assign LD_DONE  = ld_done_q;
   assign LD_ERR   = ld_err_q;

endmodule

// File: tb/tb_prog_memory.sv
// Scoreboard bench for prog_memory: default instance plus a 16x16 FILL=FFFF instance.
module tb_prog_memory;

   typedef enum int {K_READY, K_LDRDY, K_DONE, K_ERR, K_DATA, K_READY_B, K_DONE_B, K_ERR_B} kind_t;
   typedef struct {
      kind_t       kind;
      string       name;
      logic [15:0] exp;
   } chk_t;
   typedef struct {
      string       name;
      logic [15:0] exp;
   } rd_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   logic [5:0]  addr;
   logic        rd_en;
   logic [7:0]  data;
   logic        ready, ld_start, ld_valid, ld_last, ld_ready, ld_done, ld_err;
   logic [7:0]  ld_data;

   logic [3:0]  b_addr;
   logic        b_rd_en;
   logic [15:0] b_data;
   logic        b_ready, b_ld_start, b_ld_valid, b_ld_last, b_ld_ready, b_ld_done, b_ld_err;
   logic [15:0] b_ld_data;

   prog_memory u_dut (
      .CLK(CLK), .RST(RST), .ADDR(addr), .RD_EN(rd_en), .DATA(data), .READY(ready),
      .LD_START(ld_start), .LD_VALID(ld_valid), .LD_DATA(ld_data), .LD_LAST(ld_last),
      .LD_READY(ld_ready), .LD_DONE(ld_done), .LD_ERR(ld_err)
   );

   prog_memory #(.ADDR_W(4), .DATA_W(16), .FILL(16'hFFFF)) u_dut_b (
      .CLK(CLK), .RST(RST), .ADDR(b_addr), .RD_EN(b_rd_en), .DATA(b_data), .READY(b_ready),
      .LD_START(b_ld_start), .LD_VALID(b_ld_valid), .LD_DATA(b_ld_data), .LD_LAST(b_ld_last),
      .LD_READY(b_ld_ready), .LD_DONE(b_ld_done), .LD_ERR(b_ld_err)
   );

   int   checks = 0;
   int   failures = 0;
   chk_t ctl_q[$];
   rd_t  rd_q[$];
   rd_t  rdb_q[$];
   logic rd_seen = 1'b0;
   logic b_rd_seen = 1'b0;

   logic [7:0] img [8] = '{8'h84, 8'h20, 8'h00, 8'hC0, 8'hBD, 8'h44, 8'hC0, 8'hC7};

   always @(posedge CLK) begin
      rd_seen   <= rd_en;
      b_rd_seen <= b_rd_en;
   end

   task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
      end
   endtask

   // Monitor: every compare happens here, half a cycle after the active edge.
   always @(negedge CLK) begin
      chk_t        c;
      rd_t         r;
      logic [15:0] act;
      while (ctl_q.size() > 0) begin
         c = ctl_q.pop_front();
         case (c.kind)
            K_READY:   act = {15'd0, ready};
            K_LDRDY:   act = {15'd0, ld_ready};
            K_DONE:    act = {15'd0, ld_done};
            K_ERR:     act = {15'd0, ld_err};
            K_DATA:    act = {8'd0, data};
            K_READY_B: act = {15'd0, b_ready};
            K_DONE_B:  act = {15'd0, b_ld_done};
            default:   act = {15'd0, b_ld_err};
         endcase
         cmp(c.name, act, c.exp);
      end
      if (rd_seen) begin
         if (rd_q.size() == 0) cmp("rd_unexpected", {8'd0, data}, 16'hDEAD);
         else begin
            r = rd_q.pop_front();
            cmp(r.name, {8'd0, data}, r.exp);
         end
      end
      if (b_rd_seen) begin
         if (rdb_q.size() == 0) cmp("rdb_unexpected", b_data, 16'hDEAD);
         else begin
            r = rdb_q.pop_front();
            cmp(r.name, b_data, r.exp);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_ctl(input kind_t k, input string n, input logic [15:0] e);
      chk_t c;
      c.kind = k; c.name = n; c.exp = e;
      ctl_q.push_back(c);
   endtask

   task automatic push_rd(input string n, input logic [7:0] e);
      rd_t r;
      r.name = n; r.exp = {8'd0, e};
      rd_q.push_back(r);
   endtask

   task automatic read_a(input logic [5:0] a, input logic [7:0] e, input string n);
      addr = a; rd_en = 1'b1;
      push_rd(n, e);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic read_b(input logic [3:0] a, input logic [15:0] e, input string n);
      rd_t r;
      b_addr = a; b_rd_en = 1'b1;
      r.name = n; r.exp = e;
      rdb_q.push_back(r);
      tick();
      b_rd_en = 1'b0;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic beat(input logic [7:0] d, input logic last);
      ld_valid = 1'b1; ld_data = d; ld_last = last;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      expect_ctl(K_READY, {tag, "_ready"}, 16'd0);
      expect_ctl(K_LDRDY, {tag, "_ld_ready"}, 16'd0);
      expect_ctl(K_DONE,  {tag, "_ld_done"}, 16'd0);
      expect_ctl(K_ERR,   {tag, "_ld_err"}, 16'd0);
      expect_ctl(K_DATA,  {tag, "_data"}, 16'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      addr = '0; rd_en = 0; ld_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
      b_addr = '0; b_rd_en = 0; b_ld_start = 0; b_ld_valid = 0; b_ld_data = '0; b_ld_last = 0;

      // Reset values while RST is held
      tick();
      check_reset_vals("rst");
      tick();
      RST = 1'b0;

      // Clear sequence: READY rises after exactly DEPTH edges on each instance
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (i == 15) expect_ctl(K_READY_B, "b_ready_edge15", 16'd0);
         if (i == 16) expect_ctl(K_READY_B, "b_ready_edge16", 16'd1);
         if (i == 63) expect_ctl(K_READY, "ready_edge63", 16'd0);
         if (i == 64) expect_ctl(K_READY, "ready_edge64", 16'd1);
      end
      read_a(6'h00, 8'h00, "clr_rd_00");
      read_a(6'h3F, 8'h00, "clr_rd_3f");

      // Continuous 8-beat load
      start_load();
      expect_ctl(K_LDRDY, "load_ld_ready", 16'd1);
      expect_ctl(K_READY, "load_ready_low", 16'd0);
      for (int k = 0; k < 8; k++) beat(img[k], k == 7);
      expect_ctl(K_DONE,  "load_done_pulse", 16'd1);
      expect_ctl(K_READY, "load_ready_back", 16'd1);
      expect_ctl(K_ERR,   "load_no_err", 16'd0);
      read_a(6'd0, 8'h84, "img_rd_0");
      expect_ctl(K_DONE, "load_done_single", 16'd0);
      read_a(6'd5, 8'h44, "img_rd_5");
      read_a(6'd7, 8'hC7, "img_rd_7");
      read_a(6'd8, 8'h00, "img_rd_8");

      // Gapped load with a fetch attempt during LOAD
      read_a(6'd0, 8'h84, "gap_pre_rd_0");
      start_load();
      for (int k = 0; k < 8; k++) begin
         beat(img[k], k == 7);
         if (k == 7) expect_ctl(K_DONE, "gap_done", 16'd1);
         if (k == 3) begin
            addr = 6'd5; rd_en = 1'b1;
            push_rd("gap_rd_held", 8'h84);
         end
         if (k < 7) tick();
         rd_en = 1'b0;
      end
      read_a(6'd0, 8'h84, "gap_rd_0");
      read_a(6'd5, 8'h44, "gap_rd_5");
      read_a(6'd7, 8'hC7, "gap_rd_7");
      read_a(6'd8, 8'h00, "gap_rd_8");

      // Overflow: 65 beats without LAST, 66th with LAST
      start_load();
      for (int k = 1; k <= 64; k++) beat(8'(k), 1'b0);
      expect_ctl(K_ERR, "ovf_err_at_64", 16'd0);
      beat(8'hAA, 1'b0);
      expect_ctl(K_ERR,   "ovf_err_at_65", 16'd1);
      expect_ctl(K_LDRDY, "ovf_still_load", 16'd1);
      beat(8'hBB, 1'b1);
      expect_ctl(K_DONE,  "ovf_done", 16'd1);
      expect_ctl(K_ERR,   "ovf_err_sticky", 16'd1);
      expect_ctl(K_READY, "ovf_ready", 16'd1);
      read_a(6'd0,  8'h01, "ovf_word0_nowrap");
      read_a(6'd63, 8'h40, "ovf_word63");
      // LD_START together with a fetch: fetch still served, error cleared
      ld_start = 1'b1; addr = 6'd1; rd_en = 1'b1;
      push_rd("start_with_fetch", 8'h02);
      tick();
      ld_start = 1'b0; rd_en = 1'b0;
      expect_ctl(K_ERR, "err_cleared_on_start", 16'd0);
      beat(8'h5A, 1'b1);

      // Reset in the middle of a load
      start_load();
      beat(8'h11, 1'b0);
      beat(8'h22, 1'b0);
      beat(8'h33, 1'b0);
      RST = 1'b1;
      check_reset_vals("midload_rst");
      tick();
      RST = 1'b0;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (i == 63) expect_ctl(K_READY, "rerst_ready_edge63", 16'd0);
      end
      expect_ctl(K_READY, "rerst_ready_edge64", 16'd1);
      read_a(6'd0, 8'h00, "rerst_rd_0");
      read_a(6'd1, 8'h00, "rerst_rd_1");

      // 16-word, 16-bit instance with FFFF fill
      read_b(4'd3,  16'hFFFF, "b_fill_rd_3");
      read_b(4'd15, 16'hFFFF, "b_fill_rd_15");
      b_ld_start = 1'b1;
      tick();
      b_ld_start = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         b_ld_valid = 1'b1; b_ld_data = 16'h1000 + 16'(k); b_ld_last = (k == 16);
         tick();
      end
      b_ld_valid = 1'b0; b_ld_last = 1'b0;
      expect_ctl(K_DONE_B,  "b_done", 16'd1);
      expect_ctl(K_ERR_B,   "b_no_err", 16'd0);
      expect_ctl(K_READY_B, "b_ready_after_load", 16'd1);
      read_b(4'd0,  16'h1001, "b_rd_0");
      read_b(4'd15, 16'h1010, "b_rd_15");

      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_memory.md
# prog_memory

Parametrised, writable program memory for the processing unit, replacing the fixed instruction ROM. On reset it fills every word with the NOP encoding. A word-serial load port with valid/ready handshake then programs it, and the CPU fetch side reads it with one-cycle registered latency. It sits between the CPU fetch stage and the external program loader.

## Interface

Parameters:
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, instruction word width.
- FILL, {DATA_W{1'b0}} (NOP), value written to every word during clear.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ADDR  in  ADDR_W  fetch address.
- RD_EN  in  1  fetch request.
- DATA  out  DATA_W  registered fetch data.
- READY  out  1  memory usable for fetch.
- LD_START  in  1  begin a load session.
- LD_VALID  in  1  load word valid.
- LD_DATA  in  DATA_W  load word.
- LD_LAST  in  1  marks final word of session.
- LD_READY  out  1  load word accepted when LD_VALID && LD_READY.
- LD_DONE  out  1  one-cycle pulse at end of session.
- LD_ERR  out  1  sticky overflow flag.

## Operation

- FSM states: CLEAR, IDLE, LOAD. Reset enters CLEAR with pointer = 0.
- CLEAR:
  - Writes FILL at the pointer each cycle, then increments the pointer.
  - After writing DEPTH-1, goes to IDLE.
  - READY=0, LD_READY=0. LD_START and RD_EN are ignored.
- IDLE:
  - READY=1.
  - RD_EN: DATA <= mem[ADDR] at the edge. Otherwise DATA holds.
  - LD_START: goes to LOAD, pointer <= 0, LD_ERR <= 0. An RD_EN in the same cycle is still serviced.
- LOAD:
  - READY=0, LD_READY=1. RD_EN is ignored and DATA holds.
  - On each accepted beat: if the pointer has not wrapped, mem[pointer] <= LD_DATA and the pointer increments.
  - An accepted beat after DEPTH words have been written is dropped (no write, no wrap) and sets LD_ERR.
  - Accepted beat with LD_LAST: goes to IDLE; LD_DONE=1 for the following cycle only.
  - LD_START in LOAD is ignored.
- Words beyond the loaded length keep their prior contents; a load does not clear them.
- Pointer is ADDR_W+1 bits so the full-memory condition is distinguishable from address 0.
- Reset at any point, including mid-load: state returns to CLEAR and the memory is fully refilled.

## Timing

- Reset values:
  - DATA=0, READY=0, LD_READY=0, LD_DONE=0, LD_ERR=0.
  - State CLEAR, pointer 0.
- READY and LD_READY are decoded from the registered state, so there is no combinational path from inputs.
- First edge after RST deasserts writes word 0. READY rises after exactly DEPTH edges.
- Fetch latency is 1 cycle: ADDR/RD_EN sampled at edge N gives DATA valid after edge N.
- Load throughput is one word per cycle at LD_VALID=1 continuously.
- LD_LAST beat at edge N:
  - State is IDLE and READY=1 after edge N.
  - LD_DONE is high between edges N and N+1.
  - A fetch can be issued at edge N+1.
- LD_ERR asserts after the first dropped beat's edge and holds until the next LD_START or reset.

## Structure

- Package prog_memory_pkg holds:
  - State enum (CLEAR, IDLE, LOAD).
  - Default NOP constant.
  - Function computing DEPTH from ADDR_W.
- Sub-module prog_memory_array: single-port synchronous RAM (one address, write enable, write data, registered read), DEPTH x DATA_W.
  - No reset on the array.
  - The top level muxes its address among the clear pointer, load pointer and ADDR. Modes are mutually exclusive, so a single port suffices.

## Test plan

- Reset release, defaults (ADDR_W=6, DATA_W=8) -> READY=0 for 64 cycles, then 1; RD_EN at ADDR 0x00/0x3F -> DATA 0x00 next cycle.
- Load 8 beats 0x84,0x20,0x00,0xC0,0xBD,0x44,0xC0,0xC7, LAST on 8th -> LD_DONE single pulse; reads ADDR 0->0x84, 5->0x44, 7->0xC7, 8->0x00.
- Load with LD_VALID toggling every other cycle plus an RD_EN during LOAD -> same memory image as above; DATA unchanged during LOAD.
- 65 beats without LAST, then a 66th with LAST -> LD_ERR=1 after beat 65; word 0 equals beat 1 (no wrap); LD_DONE pulses; LD_ERR clears on next LD_START.
- Reset asserted after 3 accepted beats -> outputs at reset values immediately; after 64 cycles READY=1 and ADDR 0 reads 0x00.
- ADDR_W=4, DATA_W=16, FILL=16'hFFFF -> READY after 16 cycles; any read returns 0xFFFF; 16-beat load fills memory with LD_ERR=0.
